// File: rtl/svfloat_normalizer_pipe.sv
// svfloat_normalizer_pipe
//   Pipelined normalize / round / pack stage that sits behind an arithmetic
//   core (add, mul, fma). The input value is d_man * 2^(d_exp - frac). It is
//   normalized, aligned for gradual underflow when tiny, rounded in one of
//   five IEEE-754 modes, and packed as {sign, exponent, mantissa}. The block
//   also produces the {NV, DZ, OF, UF, NX} exception flags.
//
//   Pipeline: stages = 2 puts leading-one detect, normalize and denormal
//   alignment in stage 1, and rounding and packing in stage 2. Any other
//   value of stages builds a single stage that does both. The whole pipe
//   advances together whenever in_ready is high.
//
//   Optional feature: define SVFLOAT_NORM_FTZ_EN to flush tiny results to a
//   signed zero with UF and NX set. No denormal shifter is built in that case.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   in_valid / in_ready input handshake (in_ready = !out_valid || out_ready)
//   is_nan/is_inf/is_zero  overrides, priority nan > inf > zero
//   rm                  0 RNE, 1 RTZ, 2 RDN, 3 RUP, 4 RMM, others RNE
//   d_sign, d_exp, d_man   sign, signed unbiased exponent, unsigned mantissa
//   out_valid/out_ready output handshake
//   res                 packed float {sign, exponent, mantissa}
//   flags               {NV, DZ, OF, UF, NX}; NV and DZ are always 0
module svfloat_normalizer_pipe #(
  parameter int exp_width = 8,
  parameter int man_width = 23,
  parameter int ewidth    = 10,
  parameter int width     = 50,
  parameter int frac      = 46,
  parameter int stages    = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         is_inf,
  input  logic                         is_nan,
  input  logic                         is_zero,
  input  logic [2:0]                   rm,
  input  logic                         d_sign,
  input  logic [ewidth-1:0]            d_exp,
  input  logic [width-1:0]             d_man,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [exp_width+man_width:0] res,
  output logic [4:0]                   flags
);

  // Exponent arithmetic runs two bits wider than d_exp, so it cannot wrap.
  localparam int xw   = ewidth + 2;
  localparam int lw   = $clog2(width);
  localparam int mw1  = man_width + 1;
  localparam int kmax = man_width + 2;
  localparam int shw  = width + kmax;
  localparam int bias = (1 << (exp_width - 1)) - 1;

  localparam logic [xw-1:0] emin_x = xw'(1 - bias);
  localparam logic [xw-1:0] bias_x = xw'(bias);
  localparam logic [xw-1:0] frac_x = xw'(frac);
  localparam logic [xw-1:0] einf_x = xw'((1 << exp_width) - 1);

  localparam logic [1:0] k_fin  = 2'd0;
  localparam logic [1:0] k_zero = 2'd1;
  localparam logic [1:0] k_inf  = 2'd2;
  localparam logic [1:0] k_nan  = 2'd3;

  localparam logic [2:0] rm_rtz = 3'd1;
  localparam logic [2:0] rm_rdn = 3'd2;
  localparam logic [2:0] rm_rup = 3'd3;
  localparam logic [2:0] rm_rmm = 3'd4;

  // bexp is the biased exponent before rounding; it is 0 for tiny values.
  typedef struct packed {
    logic            sign;
    logic [2:0]      rm;
    logic [1:0]      kind;
    logic            tiny;
    logic [xw-1:0]   bexp;
    logic [mw1-1:0]  mant;
    logic            g;
    logic            s;
  } norm_t;

  logic [lw-1:0]   lead_s;
  logic [lw-1:0]   nshift_s;
  logic [width-1:0] norm_s;
  logic [xw-1:0]   exp_s;
  logic            tiny_s;
  logic [shw-1:0]  vec_s;
  norm_t           s1_s;

  // Leading-one detect: index of the highest set bit of d_man.
  always_comb begin
    lead_s = '0;
    for (int i = 0; i < width; i++) begin
      lead_s = d_man[i] ? lw'(i) : lead_s;
    end
  end

  // Move the leading one to the top bit and find the exponent of that bit.
  always_comb begin
    nshift_s = lw'(width - 1) - lead_s;
    norm_s   = d_man << nshift_s;
    exp_s    = {{2{d_exp[ewidth-1]}}, d_exp} + xw'(lead_s) - frac_x;
    tiny_s   = $signed(exp_s) < $signed(emin_x);
  end

`ifdef SVFLOAT_NORM_FTZ_EN
  // Tiny values get flushed at pack time, so the bits stay unshifted.
  always_comb begin
    vec_s = {norm_s, {kmax{1'b0}}};
  end
`else
  logic [xw-1:0] dk_s;
  logic [4:0]    kcap_s;

  // Denormal alignment: shift right by (emin - exp). The shift saturates at
  // kmax, because by then every significant bit lies in the sticky field.
  always_comb begin
    dk_s = emin_x - exp_s;
    if (!tiny_s) begin
      kcap_s = 5'd0;
    end else if (dk_s > xw'(kmax)) begin
      kcap_s = 5'(kmax);
    end else begin
      kcap_s = dk_s[4:0];
    end
    vec_s = {norm_s, {kmax{1'b0}}} >> kcap_s;
  end
`endif

  // Classify the beat and split the aligned bits into mantissa, guard and sticky.
  always_comb begin
    s1_s.sign = d_sign;
    s1_s.rm   = rm;
    s1_s.tiny = tiny_s;
    s1_s.bexp = tiny_s ? {xw{1'b0}} : (exp_s + bias_x);
    s1_s.mant = vec_s[shw-1 -: mw1];
    s1_s.g    = vec_s[shw-1-mw1];
    s1_s.s    = |vec_s[shw-2-mw1:0];
    if (is_nan) begin
      s1_s.kind = k_nan;
    end else if (is_inf) begin
      s1_s.kind = k_inf;
    end else if (is_zero || (d_man == {width{1'b0}})) begin
      s1_s.kind = k_zero;
    end else begin
      s1_s.kind = k_fin;
    end
  end

  logic  adv_s;
  logic  v2_s;
  norm_t p_s;

  assign in_ready = !out_valid || out_ready;
  assign adv_s    = in_ready;

  generate
    if (stages == 2) begin : g_two
      logic  v1_r;
      norm_t p1_r;

      // Stage-1 register: holds the normalized beat while the pipe is stalled.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          v1_r <= 1'b0;
          p1_r <= '0;
        end else if (adv_s) begin
          v1_r <= in_valid;
          if (in_valid) begin
            p1_r <= s1_s;
          end
        end
      end

      assign v2_s = v1_r;
      assign p_s  = p1_r;
    end else begin : g_one
      assign v2_s = in_valid;
      assign p_s  = s1_s;
    end
  endgenerate

  logic                         inc_s;
  logic                         to_inf_s;
  logic                         nx_s;
  logic                         flush_s;
  logic [mw1:0]                 mrnd_s;
  logic [xw-1:0]                exp_r_s;
  logic [man_width-1:0]         fr_s;
  logic [exp_width+man_width:0] res_s;
  logic [4:0]                   flags_s;

`ifdef SVFLOAT_NORM_FTZ_EN
  assign flush_s = p_s.tiny;
`else
  assign flush_s = 1'b0;
`endif

  // Decode the round increment, and whether an overflow saturates to infinity.
  always_comb begin
    case (p_s.rm)
      rm_rtz: begin
        inc_s    = 1'b0;
        to_inf_s = 1'b0;
      end
      rm_rdn: begin
        inc_s    = p_s.sign & (p_s.g | p_s.s);
        to_inf_s = p_s.sign;
      end
      rm_rup: begin
        inc_s    = !p_s.sign & (p_s.g | p_s.s);
        to_inf_s = !p_s.sign;
      end
      rm_rmm: begin
        inc_s    = p_s.g;
        to_inf_s = 1'b1;
      end
      default: begin
        inc_s    = p_s.g & (p_s.s | p_s.mant[0]);
        to_inf_s = 1'b1;
      end
    endcase
  end

  // Apply the increment. A carry out bumps the exponent (the mantissa field
  // wraps to 0 by itself). A denormal that rounds up into the hidden bit
  // becomes the minimum normal, with biased exponent 1.
  always_comb begin
    nx_s   = p_s.g | p_s.s;
    mrnd_s = {1'b0, p_s.mant} + {{mw1{1'b0}}, inc_s};
    fr_s   = mrnd_s[man_width-1:0];
    if (p_s.tiny) begin
      exp_r_s = {{(xw-1){1'b0}}, mrnd_s[man_width]};
    end else begin
      exp_r_s = p_s.bexp + {{(xw-1){1'b0}}, mrnd_s[mw1]};
    end
  end

  // Choose the packed result and flags: overrides, flush, overflow or finite.
  always_comb begin
    res_s   = '0;
    flags_s = 5'b00000;
    case (p_s.kind)
      k_nan: begin
        res_s = {p_s.sign, {exp_width{1'b1}}, 1'b1, {(man_width-1){1'b0}}};
      end
      k_inf: begin
        res_s = {p_s.sign, {exp_width{1'b1}}, {man_width{1'b0}}};
      end
      k_zero: begin
        res_s = {p_s.sign, {(exp_width+man_width){1'b0}}};
      end
      default: begin
        if (flush_s) begin
          res_s   = {p_s.sign, {(exp_width+man_width){1'b0}}};
          flags_s = 5'b00011;
        end else if ($signed(exp_r_s) >= $signed(einf_x)) begin
          flags_s = 5'b00101;
          if (to_inf_s) begin
            res_s = {p_s.sign, {exp_width{1'b1}}, {man_width{1'b0}}};
          end else begin
            res_s = {p_s.sign, {(exp_width-1){1'b1}}, 1'b0, {man_width{1'b1}}};
          end
        end else begin
          res_s   = {p_s.sign, exp_r_s[exp_width-1:0], fr_s};
          flags_s = {3'b000, p_s.tiny & nx_s, nx_s};
        end
      end
    endcase
  end

  // Output register: takes a new result each time the pipe advances.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      res       <= '0;
      flags     <= 5'b00000;
    end else if (adv_s) begin
      out_valid <= v2_s;
      if (v2_s) begin
        res   <= res_s;
        flags <= flags_s;
      end
    end
  end

endmodule
